// File: rtl/card_pkg.sv
// Shared constants, FSM state type and rank-to-value helper for the card dealer.
package card_pkg;

  localparam int DECK_SIZE = 52;

  localparam logic [3:0] RANK_A = 4'd1;
  localparam logic [3:0] RANK_J = 4'd11;
  localparam logic [3:0] RANK_Q = 4'd12;
  localparam logic [3:0] RANK_K = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHUF  = 2'd2,
    READY = 2'd3
  } state_t;

  // Blackjack value; face cards count 10, the ace is reported as 1.
  function automatic logic [4:0] rank_to_value(input logic [3:0] rank);
    if (rank >= RANK_J) return 5'd10;
    return {1'b0, rank};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clock,
  input  logic       reset_n,
  output logic [7:0] q
);

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) q <= SEED;
    else          q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/card_dealer.sv
// 52-card deck builder, Fisher-Yates shuffler and one-card-per-cycle dealer.
// Handshake: deal_req is sampled every cycle in READY; a card is presented with a one-cycle card_valid pulse.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       shuffle,
  input  logic       deal_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [4:0] card_value,
  output logic       ready,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  localparam logic [5:0] LAST_SLOT = 6'(DECK_SIZE - 1);

  state_t     state;
  logic [5:0] i;
  logic [5:0] top;
  logic [3:0] init_rank;
  logic [3:0] deck [DECK_SIZE];
  logic [7:0] lfsr_q;
  logic [5:0] j;
  logic [1:0] unused_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock   (Clock),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  assign j           = lfsr_q[5:0];
  assign unused_lfsr = lfsr_q[7:6];

  // Deck storage has no reset: INIT rewrites every slot before READY is reachable.
  always_ff @(posedge Clock) begin
    if (!shuffle) begin
      if (state == INIT) begin
        deck[i] <= init_rank;
      end else if (state == SHUF && j <= i) begin
        deck[i] <= deck[j];
        deck[j] <= deck[i];
      end
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      i          <= '0;
      top        <= '0;
      init_rank  <= RANK_A;
      cards_left <= '0;
      card_valid <= 1'b0;
      card_rank  <= '0;
      card_value <= '0;
      ready      <= 1'b0;
      deck_empty <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      if (shuffle) begin
        state      <= INIT;
        i          <= '0;
        init_rank  <= RANK_A;
        cards_left <= '0;
        ready      <= 1'b0;
        deck_empty <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          INIT: begin
            init_rank <= (init_rank == RANK_K) ? RANK_A : init_rank + 4'd1;
            if (i == LAST_SLOT) state <= SHUF;
            else                i     <= i + 6'd1;
          end
          SHUF: begin
            // Out-of-range draws are simply retried on the next LFSR value.
            if (j <= i) begin
              i <= i - 6'd1;
              if (i == 6'd1) begin
                state      <= READY;
                top        <= LAST_SLOT;
                cards_left <= 6'(DECK_SIZE);
                ready      <= 1'b1;
                deck_empty <= 1'b0;
              end
            end
          end
          READY: begin
            if (deal_req && cards_left != 6'd0) begin
              card_valid <= 1'b1;
              card_rank  <= deck[top];
              card_value <= rank_to_value(deck[top]);
              top        <= top - 6'd1;
              cards_left <= cards_left - 6'd1;
              deck_empty <= (cards_left == 6'd1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, build/shuffle timing, full deals, empty deck, reshuffle and mid-shuffle reset.
module tb_card_dealer;

  logic       Clock = 1'b0;
  logic       reset_n;
  logic       shuffle;
  logic       deal_req;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [4:0] card_value;
  logic       ready;
  logic       deck_empty;
  logic [5:0] cards_left;

  int         checks   = 0;
  int         failures = 0;
  int         rank_cnt [14];
  logic [3:0] last_rank;
  int         n;
  int         pulses;

  card_dealer #(.LFSR_SEED(8'hA5)) dut (
    .Clock      (Clock),
    .reset_n    (reset_n),
    .shuffle    (shuffle),
    .deal_req   (deal_req),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_value (card_value),
    .ready      (ready),
    .deck_empty (deck_empty),
    .cards_left (cards_left)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] exp_value(input logic [3:0] rank);
    if (rank == 4'd1) return 32'd1;
    if (rank <= 4'd10) return 32'(rank);
    return 32'd10;
  endfunction

  task automatic wait_ready(output int cycles, output int valid_seen);
    cycles     = 0;
    valid_seen = 0;
    while (ready !== 1'b1 && cycles < 3000) begin
      step();
      cycles++;
      if (card_valid === 1'b1) valid_seen++;
    end
    check("ready_within_bound", 32'(cycles < 3000), 32'd1);
  endtask

  task automatic deal_deck(input string tag);
    for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
    deal_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      step();
      check({tag, "_valid"}, 32'(card_valid), 32'd1);
      check({tag, "_cards_left"}, 32'(cards_left), 32'(51 - k));
      check({tag, "_value"}, 32'(card_value), exp_value(card_rank));
      if (card_rank >= 4'd1 && card_rank <= 4'd13) rank_cnt[card_rank]++;
      else check({tag, "_rank_range"}, 32'(card_rank), 32'd1);
      last_rank = card_rank;
    end
    check({tag, "_deck_empty"}, 32'(deck_empty), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    for (int r = 1; r <= 13; r++)
      check($sformatf("%s_rank%0d_count", tag, r), 32'(rank_cnt[r]), 32'd4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_card_valid"}, 32'(card_valid), 32'd0);
    check({tag, "_card_rank"},  32'(card_rank),  32'd0);
    check({tag, "_card_value"}, 32'(card_value), 32'd0);
    check({tag, "_ready"},      32'(ready),      32'd0);
    check({tag, "_deck_empty"}, 32'(deck_empty), 32'd0);
    check({tag, "_cards_left"}, 32'(cards_left), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    shuffle  = 1'b0;
    deal_req = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");

    // Requests in IDLE go nowhere.
    reset_n  = 1'b1;
    deal_req = 1'b1;
    repeat (5) begin
      step();
      check("idle_deal_ignored", 32'(card_valid), 32'd0);
    end
    check("idle_cards_left", 32'(cards_left), 32'd0);
    check("idle_ready", 32'(ready), 32'd0);

    // Build takes 52 cycles and the shuffle at least 51 more.
    deal_req = 1'b0;
    shuffle  = 1'b1;
    step();
    shuffle  = 1'b0;
    check("init_ready_low", 32'(ready), 32'd0);
    wait_ready(n, pulses);
    check("shuffle_latency_ge_103", 32'(n >= 103), 32'd1);
    check("shuffle_latency_le_3000", 32'(n < 3000), 32'd1);
    check("first_cards_left", 32'(cards_left), 32'd52);
    check("first_deck_empty", 32'(deck_empty), 32'd0);
    check("first_no_pulse", 32'(pulses), 32'd0);

    deal_deck("deal1");

    // 53rd request on an empty deck.
    step();
    check("empty_valid", 32'(card_valid), 32'd0);
    check("empty_rank_hold", 32'(card_rank), 32'(last_rank));
    check("empty_value_hold", 32'(card_value), exp_value(last_rank));
    check("empty_deck_empty", 32'(deck_empty), 32'd1);
    check("empty_cards_left", 32'(cards_left), 32'd0);

    // Reshuffle, deal 10, then shuffle together with deal_req.
    deal_req = 1'b0;
    shuffle  = 1'b1;
    step();
    shuffle  = 1'b0;
    wait_ready(n, pulses);
    check("reshuffle_cards_left", 32'(cards_left), 32'd52);
    deal_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("partial_valid", 32'(card_valid), 32'd1);
      check("partial_value", 32'(card_value), exp_value(card_rank));
    end
    check("partial_cards_left", 32'(cards_left), 32'd42);
    shuffle = 1'b1;
    step();
    check("shuffle_wins_valid", 32'(card_valid), 32'd0);
    check("shuffle_wins_ready", 32'(ready), 32'd0);
    check("shuffle_wins_cards_left", 32'(cards_left), 32'd0);
    shuffle  = 1'b0;
    deal_req = 1'b0;
    wait_ready(n, pulses);
    check("after_restart_cards_left", 32'(cards_left), 32'd52);

    // Asynchronous reset in the middle of SHUF.
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    repeat (60) step();
    check("mid_shuf_not_ready", 32'(ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    reset_n  = 1'b1;
    deal_req = 1'b1;
    repeat (5) begin
      step();
      check("post_reset_deal_ignored", 32'(card_valid), 32'd0);
    end
    check("post_reset_cards_left", 32'(cards_left), 32'd0);

    // deal_req held through INIT/SHUF must not be queued.
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    wait_ready(n, pulses);
    check("held_req_no_pulse", 32'(pulses), 32'd0);
    check("held_req_cards_left", 32'(cards_left), 32'd52);
    deal_deck("deal2");

    deal_req = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero reset value of the shuffle LFSR.
REQ-002 SHALL have port Clock  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port shuffle  input  1  level-sampled request: rebuild and shuffle the deck.
REQ-005 SHALL have port deal_req  input  1  request for one card, sampled each cycle.
REQ-006 SHALL have port card_valid  output  1  one-cycle pulse: card_rank/card_value hold a dealt card.
REQ-007 SHALL have port card_rank  output  4  dealt rank, 1=A, 2..10, 11=J, 12=Q, 13=K.
REQ-008 SHALL have port card_value  output  5  blackjack value of card_rank: 1 for A, rank for 2..10, 10 for J/Q/K; 5 bits to add directly into 5-bit hand sums.
REQ-009 SHALL have port ready  output  1  high only in READY state.
REQ-010 SHALL have port deck_empty  output  1  high when cards_left==0 and state is READY.
REQ-011 SHALL have port cards_left  output  6  undealt cards remaining, 0..52.

Function
REQ-012 SHALL implement states IDLE, INIT, SHUF, READY.
REQ-013 SHALL hold a 52-entry deck of 4-bit ranks plus 6-bit index i and 6-bit top pointer.
REQ-014 SHALL advance an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) every cycle in every state, so the shuffle outcome depends on when shuffle is asserted.
REQ-015 IDLE: cards_left=0, ready=0; shuffle=1 -> INIT with i=0.
REQ-016 INIT: one slot per cycle, deck[i] = (i mod 13)+1 via a 1..13 wrap counter, no divider; after slot 51 -> SHUF with i=51; 52 cycles total.
REQ-017 SHUF: each cycle j = LFSR[5:0]; if j<=i, swap deck[i] and deck[j] and decrement i; if j>i, no swap, i unchanged (retry).
REQ-018 SHUF SHALL exit to READY the cycle after the swap with i=1, setting top=51 and cards_left=52.
REQ-019 READY with deal_req=1 and cards_left>0: next cycle card_valid=1, card_rank=deck[top], card_value per REQ-008; top and cards_left decrement.
REQ-020 Back-to-back deal_req SHALL produce one card per cycle, latency one cycle, no bubble.
REQ-021 READY with deal_req=1 and cards_left==0: card_valid stays 0, outputs hold, deck_empty stays 1.
REQ-022 deal_req outside READY SHALL be ignored, not queued.
REQ-023 shuffle=1 in any state, including READY mid-deal, INIT or SHUF, SHALL restart INIT with i=0 next cycle and clear cards_left.
REQ-024 shuffle and deal_req together in READY: shuffle wins, no card issued.
REQ-025 card_rank/card_value SHALL hold the last dealt card until the next deal; they are 0 after reset.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, card_valid=0, card_rank=0, card_value=0, ready=0, deck_empty=0, cards_left=0, i=0, top=0, LFSR=LFSR_SEED.
REQ-027 Deck contents need not be reset; INIT overwrites all 52 entries before any deal.
REQ-028 Reset asserted mid-INIT or mid-SHUF SHALL abandon the operation, with no partial deck dealt.

Structure
REQ-029 SHALL import card_pkg holding DECK_SIZE=52, rank constants RANK_A/J/Q/K, state enum, and function rank_to_value.
REQ-030 SHALL instantiate one sub-module lfsr8 (Clock, reset_n, seed parameter, 8-bit q).
REQ-031 SHALL keep deck in a flop array, synthesizable without RAM inference.

Verification
REQ-032 Reset, wait 5 cycles, shuffle for 1 cycle -> ready rises after 52 + SHUF cycles (>=51); cards_left=52.
REQ-033 From READY, deal_req held 52 cycles -> 52 card_valid pulses; each rank 1..13 seen exactly 4 times; cards_left reaches 0 and deck_empty=1.
REQ-034 53rd deal_req -> card_valid stays 0, card_rank unchanged, deck_empty=1.
REQ-035 Check every dealt pair: rank 1 -> value 1, rank 7 -> value 7, ranks 11/12/13 -> value 10.
REQ-036 Deal 10 cards, then assert shuffle with deal_req -> no card_valid; ready drops next cycle; after reshuffle cards_left=52.
REQ-037 Assert reset_n=0 for 1 cycle mid-SHUF -> all outputs at reset values immediately; deal_req ignored until a new shuffle completes.
